dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  master clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 address_dmem  input  32  word address from the processor M stage.
REQ-005 data  input  32  store data from the processor.
REQ-006 wren  input  1  store enable.
REQ-007 q_dmem  output  32  load data returned to the processor.
REQ-008 out_valid  output  1  output FIFO head valid.
REQ-009 out_data  output  32  output FIFO head word.
REQ-010 out_ready  input  1  external consumer accepts the head word.
REQ-011 Parameter RAM_WORDS, default 1024, number of 32-bit RAM words (power of two).
REQ-012 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, at least 2).

Function
REQ-013 Address map: RAM at 0 to RAM_WORDS-1; CYCLE at 0x1000; OUT at 0x1001; STATUS at 0x1002; all other addresses unmapped.
REQ-014 Address decode SHALL compare all 32 address bits; no aliasing.
REQ-015 q_dmem SHALL be combinational from the current address_dmem and current state, so it is valid within the same cycle.
REQ-016 RAM read returns the stored word; RAM write stores data at the rising edge when wren=1.
REQ-017 Read-during-write to the same RAM word SHALL return the old contents in that cycle.
REQ-018 CYCLE read returns the 32-bit cycle counter.
REQ-019 The cycle counter SHALL increment by 1 every non-reset cycle and wrap from 0xFFFFFFFF to 0.
REQ-020 Writes to CYCLE SHALL be ignored.
REQ-021 OUT reads SHALL return 0.
REQ-022 An OUT write SHALL push data into the FIFO if it is not full, or if a pop occurs in the same cycle.
REQ-023 An OUT write that is not accepted SHALL be dropped and SHALL set the sticky overflow flag.
REQ-024 STATUS read SHALL return: bit0 empty; bit1 full; bit2 overflow; bits[6:3] count (0..FIFO_DEPTH); all other bits 0.
REQ-025 Any STATUS write SHALL clear overflow.
REQ-026 If a STATUS write and an overflowing OUT write coincide, overflow clear SHALL win; this cannot happen in one cycle given a single address, so it applies only to future multi-port variants.
REQ-027 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored with no side effects.
REQ-028 out_valid SHALL equal not empty; out_data SHALL equal the head entry, and 0 when empty.
REQ-029 A pop SHALL occur when out_valid and out_ready are both 1 at the rising edge.
REQ-030 When empty, a push and out_ready=1 in the same cycle SHALL NOT pop; the word becomes valid the next cycle.
REQ-031 FIFO order SHALL be strictly first-in first-out, using wrap-around read and write pointers and a separate count.
REQ-032 With wren=0, no state changes except the cycle counter and FIFO pops.

Reset
REQ-033 While reset=1 at a rising edge, the following SHALL be cleared: cycle counter to 0, FIFO pointers and count to 0, overflow to 0.
REQ-034 RAM contents SHALL be retained through reset.
REQ-035 While reset is high, q_dmem SHALL be 0 and out_valid SHALL be 0.
REQ-036 Writes while reset is high SHALL be ignored.
REQ-037 Reset asserted mid-stream SHALL discard all FIFO contents.

Verification
REQ-038 RAM store/load: write 0xDEADBEEF to addr 5, then read addr 5 -> 0xDEADBEEF. Read addr 5 while writing 0x1 to addr 5 -> 0xDEADBEEF that cycle, 0x1 the next cycle.
REQ-039 Counter: release reset, wait 10 edges, read 0x1000 -> 10. Write 0x55 to 0x1000 -> ignored. Preload by forcing to 0xFFFFFFFF, then one edge -> 0.
REQ-040 FIFO fill/overflow: with out_ready=0, write 1..5 to 0x1001 -> STATUS=0x22 (full, count4), then 0x26 after the fifth write. Write 0 to 0x1002 -> overflow cleared. Drain with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, then out_valid=0.
REQ-041 Full with simultaneous pop and push: with FIFO full and out_ready=1, write 9 to OUT -> accepted, count stays 4, no overflow, and 9 emerges last.
REQ-042 Empty push with out_ready=1: write 7 -> out_valid=0 that cycle, then out_valid=1 and out_data=7 the next cycle, popped at the following edge.
REQ-043 Reset mid-operation: two entries queued and counter at 20, assert reset one cycle -> out_valid=0, STATUS=0x1, counter restarts at 0, RAM addr 5 still holds its value.

Source files
------------

// File: rtl/dmem_mmio_if.sv
// Processor data-memory port plus the output-FIFO stream port of dmem_mmio.
// master = processor/consumer side, slave = the memory/MMIO block.
interface dmem_mmio_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output address_dmem, data, wren, out_ready,
    input  q_dmem, out_valid, out_data
  );

  modport slave (
    input  address_dmem, data, wren, out_ready,
    output q_dmem, out_valid, out_data
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped cycle counter, output FIFO and status register.
// Loads are combinational; stores, pushes and pops commit on the rising clock edge.
module dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clock,
  input logic        reset,
  dmem_mmio_if.slave bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [31:0] RAM_LIMIT   = 32'(RAM_WORDS);
  localparam logic [31:0] ADDR_CYCLE  = 32'h0000_1000;
  localparam logic [31:0] ADDR_OUT    = 32'h0000_1001;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1002;
  localparam logic [PW:0] DEPTH_CNT   = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycle_cnt;

  logic          ram_hit;
  logic          cycle_hit;
  logic          out_hit;
  logic          status_hit;
  logic [AW-1:0] ram_idx;
  logic          empty;
  logic          full;
  logic          wr_active;
  logic          pop;
  logic          push;
  logic [31:0]   status_word;

  // Full 32-bit compares so nothing aliases into the register window.
  assign ram_hit    = bus.address_dmem < RAM_LIMIT;
  assign cycle_hit  = bus.address_dmem == ADDR_CYCLE;
  assign out_hit    = bus.address_dmem == ADDR_OUT;
  assign status_hit = bus.address_dmem == ADDR_STATUS;
  assign ram_idx    = bus.address_dmem[AW-1:0];

  assign empty     = count == '0;
  assign full      = count == DEPTH_CNT;
  assign wr_active = bus.wren && !reset;
  // A push into an empty FIFO is not visible to the consumer until the next cycle.
  assign pop       = !empty && bus.out_ready && !reset;
  assign push      = wr_active && out_hit && (!full || pop);

  always_comb begin
    status_word             = '0;
    status_word[0]          = empty;
    status_word[1]          = full;
    status_word[2]          = overflow;
    status_word[3 +: PW+1]  = count;
  end

  always_comb begin
    bus.q_dmem = '0;
    if (!reset) begin
      if (ram_hit)         bus.q_dmem = ram[ram_idx];
      else if (cycle_hit)  bus.q_dmem = cycle_cnt;
      else if (status_hit) bus.q_dmem = status_word;
    end
  end

  assign bus.out_valid = !empty && !reset;
  assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr] : '0;

  // RAM and FIFO storage are never reset; only pointers and flags are.
  always_ff @(posedge clock) begin
    if (wr_active && ram_hit) ram[ram_idx] <= bus.data;
    if (push) fifo_mem[wr_ptr] <= bus.data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      // Clear takes priority over a coincident set.
      if (wr_active && status_hit)
        overflow <= 1'b0;
      else if (wr_active && out_hit && !push)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed sequences, a vector table and
// randomized traffic compared against a queue-based reference model.
module tb_dmem_mmio;

  localparam int RAM_W = 64;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_CYC = 32'h1000;
  localparam logic [31:0] A_OUT = 32'h1001;
  localparam logic [31:0] A_STS = 32'h1002;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_WORDS(RAM_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ram [RAM_W];
  bit          m_known [RAM_W];
  logic [31:0] m_cycle = '0;
  logic [31:0] m_fifo [$];
  bit          m_ovf = 1'b0;

  logic [31:0] sq, sd;
  logic        sv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int sz = m_fifo.size();
    return (32'(sz) << 3) | (32'(m_ovf) << 2) | (32'(sz == DEPTH) << 1) | 32'(sz == 0);
  endfunction

  // One clock cycle: drive, sample before the edge, check against the model,
  // advance the model, then cross the edge and return at the falling edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic rdy, input logic rst,
                      output logic [31:0] q_s, output logic v_s, output logic [31:0] od_s);
    logic [31:0] exp_q;
    bit          q_known;
    bit          exp_v;
    bit          popping;
    bit          accept;
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = we;
    bus.out_ready    = rdy;
    reset            = rst;
    #1;
    q_s  = bus.q_dmem;
    v_s  = bus.out_valid;
    od_s = bus.out_data;

    q_known = 1'b1;
    exp_q   = '0;
    if (!rst) begin
      if (a < RAM_W) begin
        q_known = m_known[a];
        exp_q   = m_ram[a];
      end else if (a == A_CYC) exp_q = m_cycle;
      else if (a == A_STS)     exp_q = model_status();
    end
    if (q_known) check("q_dmem", q_s, exp_q);
    exp_v = !rst && (m_fifo.size() > 0);
    check("out_valid", 32'(v_s), 32'(exp_v));
    if (exp_v)     check("out_data", od_s, m_fifo[0]);
    else if (!rst) check("out_data_empty", od_s, 32'h0);

    if (rst) begin
      m_cycle = '0;
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      m_cycle = m_cycle + 32'd1;
      popping = (m_fifo.size() > 0) && rdy;
      accept  = 1'b0;
      if (we) begin
        if (a < RAM_W) begin
          m_ram[a]   = d;
          m_known[a] = 1'b1;
        end else if (a == A_OUT) begin
          if (m_fifo.size() < DEPTH || popping) accept = 1'b1;
          else m_ovf = 1'b1;
        end else if (a == A_STS) begin
          m_ovf = 1'b0;
        end
      end
      if (popping) void'(m_fifo.pop_front());
      if (accept) m_fifo.push_back(d);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        rdy;
    logic [31:0] exp_q;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic rdy, input logic [31:0] eq, input logic ev,
                              input logic [31:0] ed);
    vec_t v;
    v.addr = a; v.data = d; v.we = we; v.rdy = rdy;
    v.exp_q = eq; v.exp_v = ev; v.exp_d = ed;
    return v;
  endfunction

  vec_t vecs [$];

  initial begin
    for (int i = 0; i < RAM_W; i++) m_known[i] = 1'b0;
    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;
    bus.out_ready    = 1'b0;

    // Starting from an empty FIFO with RAM[i] = 3*i+1.
    vecs.push_back(mk(A_OUT, 32'd1, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(A_OUT, 32'd2, 1, 0, 32'h0, 1, 32'd1));
    vecs.push_back(mk(A_OUT, 32'd3, 1, 0, 32'h0, 1, 32'd1));
    vecs.push_back(mk(A_OUT, 32'd4, 1, 0, 32'h0, 1, 32'd1));
    vecs.push_back(mk(A_STS, 32'd0, 0, 0, 32'h22, 1, 32'd1));
    vecs.push_back(mk(A_OUT, 32'd5, 1, 0, 32'h0, 1, 32'd1));
    vecs.push_back(mk(A_STS, 32'd0, 0, 0, 32'h26, 1, 32'd1));
    vecs.push_back(mk(A_STS, 32'd0, 1, 0, 32'h26, 1, 32'd1));
    vecs.push_back(mk(A_STS, 32'd0, 0, 0, 32'h22, 1, 32'd1));
    vecs.push_back(mk(A_OUT, 32'd0, 0, 1, 32'h0, 1, 32'd1));
    vecs.push_back(mk(32'h0, 32'd0, 0, 1, 32'd1, 1, 32'd2));
    vecs.push_back(mk(32'h3F, 32'd0, 0, 1, 32'd190, 1, 32'd3));
    vecs.push_back(mk(32'h40, 32'd0, 0, 1, 32'h0, 1, 32'd4));
    vecs.push_back(mk(A_STS, 32'd0, 0, 0, 32'h01, 0, 32'h0));
    vecs.push_back(mk(32'h8000_1001, 32'h77, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(32'h40, 32'hAB, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(32'h1003, 32'd0, 0, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(A_STS, 32'd0, 0, 0, 32'h01, 0, 32'h0));
    vecs.push_back(mk(32'h8000_1002, 32'd0, 0, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(32'h3, 32'd0, 0, 0, 32'd10, 0, 32'h0));
    vecs.push_back(mk(32'h0, 32'd0, 0, 0, 32'd1, 0, 32'h0));

    @(negedge clock);
    // Reset state and RAM preload
    step(0, 0, 0, 0, 1, sq, sv, sd);
    check("reset_q", sq, 32'h0);
    check("reset_valid", 32'(sv), 32'h0);
    step(A_OUT, 32'h99, 1, 1, 1, sq, sv, sd);
    step(A_STS, 0, 0, 0, 0, sq, sv, sd);
    check("status_after_reset", sq, 32'h01);
    for (int i = 0; i < RAM_W; i++) step(32'(i), 32'(3 * i + 1), 1, 0, 0, sq, sv, sd);

    // RAM store/load and read-during-write
    step(5, 32'hDEAD_BEEF, 1, 0, 0, sq, sv, sd);
    step(5, 32'h1, 1, 0, 0, sq, sv, sd);
    check("rdw_old", sq, 32'hDEAD_BEEF);
    step(5, 0, 0, 0, 0, sq, sv, sd);
    check("rdw_new", sq, 32'h1);
    step(5, 32'hDEAD_BEEF, 1, 0, 0, sq, sv, sd);

    // Cycle counter
    step(0, 0, 0, 0, 1, sq, sv, sd);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, sq, sv, sd);
    step(A_CYC, 0, 0, 0, 0, sq, sv, sd);
    check("cycle_10", sq, 32'd10);
    step(A_CYC, 32'h55, 1, 0, 0, sq, sv, sd);
    step(A_CYC, 0, 0, 0, 0, sq, sv, sd);
    check("cycle_wr_ignored", sq, 32'd12);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cycle = 32'hFFFF_FFFF;
    step(A_CYC, 0, 0, 0, 0, sq, sv, sd);
    check("cycle_max", sq, 32'hFFFF_FFFF);
    step(A_CYC, 0, 0, 0, 0, sq, sv, sd);
    check("cycle_wrap", sq, 32'h0);

    // Vector table: fill, overflow, clear, drain, unmapped accesses
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].rdy, 0, sq, sv, sd);
      check($sformatf("vec%0d_q", i), sq, vecs[i].exp_q);
      check($sformatf("vec%0d_valid", i), 32'(sv), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_data", i), sd, vecs[i].exp_d);
    end

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) step(A_OUT, 32'(11 + i), 1, 0, 0, sq, sv, sd);
    step(A_OUT, 32'd9, 1, 1, 0, sq, sv, sd);
    check("full_pp_head", sd, 32'd11);
    step(A_STS, 0, 0, 0, 0, sq, sv, sd);
    check("full_pp_status", sq, 32'h22);
    step(0, 0, 0, 1, 0, sq, sv, sd); check("drain_12", sd, 32'd12);
    step(0, 0, 0, 1, 0, sq, sv, sd); check("drain_13", sd, 32'd13);
    step(0, 0, 0, 1, 0, sq, sv, sd); check("drain_14", sd, 32'd14);
    step(0, 0, 0, 1, 0, sq, sv, sd); check("drain_9", sd, 32'd9);
    step(0, 0, 0, 1, 0, sq, sv, sd); check("drained_valid", 32'(sv), 32'h0);

    // Empty push with consumer ready
    step(A_OUT, 32'd7, 1, 1, 0, sq, sv, sd);
    check("empty_push_valid", 32'(sv), 32'h0);
    step(0, 0, 0, 1, 0, sq, sv, sd);
    check("empty_push_next_valid", 32'(sv), 32'h1);
    check("empty_push_next_data", sd, 32'd7);
    step(0, 0, 0, 1, 0, sq, sv, sd);
    check("empty_push_popped", 32'(sv), 32'h0);

    // Reset mid-operation
    step(0, 0, 0, 0, 1, sq, sv, sd);
    step(A_OUT, 32'hA1, 1, 0, 0, sq, sv, sd);
    step(A_OUT, 32'hA2, 1, 0, 0, sq, sv, sd);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 0, sq, sv, sd);
    step(A_CYC, 0, 0, 0, 0, sq, sv, sd);
    check("mid_cycle_20", sq, 32'd20);
    step(5, 32'h123, 1, 1, 1, sq, sv, sd);
    check("mid_reset_valid", 32'(sv), 32'h0);
    check("mid_reset_q", sq, 32'h0);
    step(A_CYC, 0, 0, 0, 0, sq, sv, sd);
    check("mid_cycle_restart", sq, 32'h0);
    step(A_STS, 0, 0, 0, 0, sq, sv, sd);
    check("mid_status", sq, 32'h01);
    check("mid_valid", 32'(sv), 32'h0);
    step(5, 0, 0, 0, 0, sq, sv, sd);
    check("mid_ram_kept", sq, 32'hDEAD_BEEF);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = 32'($urandom_range(0, RAM_W - 1));
        3, 4:    a = A_OUT;
        5:       a = A_STS;
        6:       a = A_CYC;
        7:       a = 32'(RAM_W);
        8:       a = 32'h1003;
        default: a = $urandom;
      endcase
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 59) == 0), sq, sv, sd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
